// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 bit-plane scanner: scan sequencer states and the
// six-bit upper/lower pixel pair as it arrives from the frame store.
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      CLK_LO,
      CLK_HI,
      BLANK,
      LATCH,
      DISPLAY
   } scan_state_t;

   typedef struct packed {
      logic r1;
      logic g1;
      logic b1;
      logic r2;
      logic g2;
      logic b2;
   } rgb_pair_t;

endpackage

// File: rtl/hub75_tick_gen.sv
// Free-running prescaler: tick is high for one clk_in cycle in every CLK_DIV.
module hub75_tick_gen
   import hub75_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk_in,
   input  logic reset,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan driver: shifts one row of a bit-plane, blanks, latches, then shows
// it for BASE_TICKS<<plane ticks with OE pulse-width dimmed by brightness.
module hub75_bcm_scanner
   import hub75_pkg::*;
#(
   parameter int COLS       = 64,
   parameter int SCAN_ROWS  = 32,
   parameter int ADDR_W     = $clog2(SCAN_ROWS),
   parameter int PLANES     = 4,
   parameter int CLK_DIV    = 4,
   parameter int BASE_TICKS = 64,
   parameter int DEAD_TICKS = 2,
   localparam int COL_W     = $clog2(COLS),
   localparam int PLANE_W   = (PLANES > 1) ? $clog2(PLANES) : 1
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         brightness,
   output logic [COL_W-1:0]   rd_col,
   output logic [ADDR_W-1:0]  rd_row,
   output logic [PLANE_W-1:0] rd_plane,
   input  logic [5:0]         rd_data,
   output logic [ADDR_W-1:0]  row_addr,
   output logic               R1,
   output logic               G1,
   output logic               B1,
   output logic               R2,
   output logic               G2,
   output logic               B2,
   output logic               CLK,
   output logic               LAT,
   output logic               OE,
   output logic               frame_done,
   output logic               busy
);

   localparam int MAX_DUR = BASE_TICKS << (PLANES - 1);
   localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
   localparam int MW      = TW + 9;
   localparam int DW      = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

   localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0]  LAST_ROW   = ADDR_W'(SCAN_ROWS - 1);
   localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);
   localparam logic [DW-1:0]      LAST_DEAD  = DW'(DEAD_TICKS - 1);

   scan_state_t state, state_n;

   logic               tick;
   logic [COL_W-1:0]   col;
   logic [COL_W:0]     col_p2;
   logic [ADDR_W-1:0]  row, row_adv;
   logic [PLANE_W-1:0] plane, plane_adv;
   logic [DW-1:0]      dead_cnt;
   logic [TW-1:0]      timer, timer_d;
   logic [TW:0]        dur, on_ticks, on_d, on_calc;
   logic [MW-1:0]      prod;
   logic               plane_last, row_last, disp_last;
   logic               clk_d, lat_d, oe_d;
   rgb_pair_t          pix;

   hub75_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_in (clk_in),
      .reset  (reset),
      .tick   (tick)
   );

   assign dur     = (TW+1)'(BASE_TICKS) << plane;
   assign prod    = MW'(dur) * (MW'(brightness) + MW'(1));
   assign on_calc = (TW+1)'(prod >> 8);

   assign plane_last = (plane == LAST_PLANE);
   assign row_last   = (row == LAST_ROW);
   assign plane_adv  = plane_last ? '0 : plane + PLANE_W'(1);
   assign row_adv    = !plane_last ? row : (row_last ? '0 : row + ADDR_W'(1));
   assign disp_last  = (state == DISPLAY) && ({1'b0, timer} == dur - (TW+1)'(1));
   assign col_p2     = {1'b0, col} + (COL_W+1)'(2);

   // Values the slot timer and on-time will hold after this tick; the pins are
   // registered from them so they line up with the state being entered.
   assign timer_d = (state == LATCH)   ? '0 :
                    (state == DISPLAY) ? timer + TW'(1) : timer;
   assign on_d    = (state == LATCH) ? on_calc : on_ticks;

   assign busy = (state != IDLE);
   assign {R1, G1, B1, R2, G2, B2} = pix;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (tick) begin
         case (state)
            IDLE:    if (enable) state_n = PRIME;
            PRIME:   state_n = CLK_LO;
            CLK_LO:  state_n = CLK_HI;
            CLK_HI:  state_n = (col == LAST_COL) ? BLANK : CLK_LO;
            BLANK:   if (dead_cnt == LAST_DEAD) state_n = LATCH;
            LATCH:   state_n = DISPLAY;
            DISPLAY: if (disp_last) state_n = enable ? PRIME : IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      clk_d = 1'b0;
      lat_d = 1'b0;
      oe_d  = 1'b1;
      case (state_n)
         CLK_HI:  clk_d = 1'b1;
         LATCH:   lat_d = 1'b1;
         DISPLAY: oe_d  = ({1'b0, timer_d} >= on_d);
         default: ;
      endcase
   end

   // Read addresses run one column ahead of the pins so rd_data has a full
   // tick to settle before it is captured on entry to CLK_LO.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         plane      <= '0;
         dead_cnt   <= '0;
         timer      <= '0;
         on_ticks   <= '0;
         rd_col     <= '0;
         rd_row     <= '0;
         rd_plane   <= '0;
         row_addr   <= '0;
         pix        <= '0;
         CLK        <= 1'b0;
         LAT        <= 1'b0;
         OE         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            CLK      <= clk_d;
            LAT      <= lat_d;
            OE       <= oe_d;
            timer    <= timer_d;
            on_ticks <= on_d;
            case (state)
               IDLE: begin
                  if (enable) begin
                     rd_col   <= '0;
                     rd_row   <= row;
                     rd_plane <= plane;
                  end
               end
               PRIME: begin
                  col    <= '0;
                  rd_col <= COL_W'(1);
                  pix    <= rgb_pair_t'(rd_data);
               end
               CLK_HI: begin
                  if (col == LAST_COL) begin
                     dead_cnt <= '0;
                     row_addr <= row;
                  end else begin
                     col    <= col + COL_W'(1);
                     rd_col <= (col_p2 > (COL_W+1)'(COLS - 1)) ? LAST_COL : col_p2[COL_W-1:0];
                     pix    <= rgb_pair_t'(rd_data);
                  end
               end
               BLANK: begin
                  if (dead_cnt != LAST_DEAD) dead_cnt <= dead_cnt + DW'(1);
               end
               DISPLAY: begin
                  if (disp_last) begin
                     plane      <= plane_adv;
                     row        <= row_adv;
                     frame_done <= plane_last && row_last;
                     if (enable) begin
                        rd_col   <= '0;
                        rd_row   <= row_adv;
                        rd_plane <= plane_adv;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
